// File: rtl/genel_histogram_birimi.sv
// genel_histogram_birimi
// Histogram / CDF / equalisation engine for a pixel stream.
//   H  (gorev_i=0): clear bins, count one frame, dump each bin as COUNT_W/8 bytes, MSB first
//   C  (gorev_i=1): as H, but each bin's dump is the running CDF
//   HE (gorev_i=2): build lut[v] = floor(cdf[v]*(BINS-1)/(IMG_W*IMG_H)) from the retained
//                   histogram, then map one frame through the LUT
// Ports:
//   clk_i, rstn_i       clock (rising edge), asynchronous active-low reset
//   basla, gorev_i      start pulse and mode, sampled only while idle (BOSTA)
//   etkin_i, pixel_i    input stream, stal_o is its backpressure
//   etkin_o, pixel_o    output stream, stal_i is its backpressure
//   mesgul_o, bitti_o   busy level, one-cycle command-complete pulse
// Handshake: a word moves on a port in every cycle where its valid (etkin_*) is high and
// its stall (stal_*) is low; a presented output word holds unchanged until it moves.
// The histogram and LUT memories have no reset so a histogram survives reset for HE.
module genel_histogram_birimi #(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int COUNT_W = 24
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               basla,
  input  logic [1:0]         gorev_i,
  input  logic               etkin_i,
  input  logic [PIXEL_W-1:0] pixel_i,
  input  logic               stal_i,
  output logic               etkin_o,
  output logic [7:0]         pixel_o,
  output logic               stal_o,
  output logic               mesgul_o,
  output logic               bitti_o
);
  localparam int BINS = 2**PIXEL_W;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NB   = COUNT_W / 8;
  localparam int PC_W = $clog2(NPIX + 1);
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int IT_W = (PIXEL_W > 1) ? $clog2(PIXEL_W) : 1;
  localparam int RW   = COUNT_W + PIXEL_W;

  generate
    if ((COUNT_W % 8) != 0 || COUNT_W < $clog2(NPIX + 1) || PIXEL_W < 1 || PIXEL_W > 8) begin : g_param_chk
      $error("genel_histogram_birimi: unsupported PIXEL_W/COUNT_W for this frame size");
    end
  endgenerate

  typedef enum logic [2:0] {BOSTA, TEMIZLE, SAY, DOK, LUT, ESITLE} durum_t;
  durum_t durum;

  logic [COUNT_W-1:0] hist [BINS];
  logic [PIXEL_W-1:0] lut  [BINS];
  logic [COUNT_W-1:0] rd_q;

  logic               mod_c;
  logic [PIXEL_W-1:0] bin_ctr;
  logic [BC_W-1:0]    byte_ctr;
  logic [COUNT_W-1:0] sh, acc;
  logic               fin;
  logic [PC_W-1:0]    pix_ctr, out_ctr;
  logic               s1_v, wr_v;
  logic [PIXEL_W-1:0] s1_addr, wr_addr;
  logic [COUNT_W-1:0] wr_data;
  logic               bolme;
  logic [IT_W-1:0]    it;
  logic [RW-1:0]      rem;
  logic [PIXEL_W-1:0] quo;
  logic               e1_v;
  logic [PIXEL_W-1:0] e1_p;

  logic               pix_full, accept, q_bit;
  logic [COUNT_W-1:0] h_rd, cdf_nx, inc_data, dump_word;
  logic [RW-1:0]      dvs;
  logic [PIXEL_W-1:0] quo_nx;
  logic               hist_we, lut_we;
  logic [PIXEL_W-1:0] hist_wa;
  logic [COUNT_W-1:0] hist_wd;

  assign mesgul_o = (durum != BOSTA);
  assign pix_full = (pix_ctr == PC_W'(NPIX));
  assign accept   = etkin_i & ~stal_o;
  assign h_rd     = hist[bin_ctr];
  assign cdf_nx   = acc + h_rd;
  // The read for the pixel in stage 1 was issued while the previous increment was still
  // being written; if both target the same bin, take the value just written instead.
  assign inc_data  = ((wr_v && wr_addr == s1_addr) ? wr_data : rd_q) + 1'b1;
  assign dump_word = (byte_ctr == '0) ? (mod_c ? cdf_nx : h_rd) : sh;
  // Restoring division: subtract NPIX<<it when it fits, one quotient bit per cycle.
  assign dvs   = RW'(NPIX) << it;
  assign q_bit = (rem >= dvs);

  always_comb begin
    quo_nx     = quo;
    quo_nx[it] = q_bit;
  end

  always_comb begin
    stal_o = 1'b1;
    if (durum == SAY)    stal_o = pix_full;
    if (durum == ESITLE) stal_o = stal_i | pix_full;
  end

  always_comb begin
    hist_we = 1'b0;
    hist_wa = bin_ctr;
    hist_wd = '0;
    if (durum == TEMIZLE) begin
      hist_we = 1'b1;
    end else if (durum == SAY && s1_v) begin
      hist_we = 1'b1;
      hist_wa = s1_addr;
      hist_wd = inc_data;
    end
    lut_we = (durum == LUT) && bolme && (it == '0);
  end

  always_ff @(posedge clk_i) begin
    if (hist_we) hist[hist_wa] <= hist_wd;
    if (lut_we)  lut[bin_ctr]  <= quo_nx;
    rd_q <= hist[pixel_i];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum    <= BOSTA;
      etkin_o  <= 1'b0;
      pixel_o  <= '0;
      bitti_o  <= 1'b0;
      mod_c    <= 1'b0;
      bin_ctr  <= '0;
      byte_ctr <= '0;
      sh       <= '0;
      acc      <= '0;
      fin      <= 1'b0;
      pix_ctr  <= '0;
      out_ctr  <= '0;
      s1_v     <= 1'b0;
      s1_addr  <= '0;
      wr_v     <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      bolme    <= 1'b0;
      it       <= '0;
      rem      <= '0;
      quo      <= '0;
      e1_v     <= 1'b0;
      e1_p     <= '0;
    end else begin
      bitti_o <= 1'b0;
      wr_v    <= 1'b0;
      unique case (durum)
        BOSTA: begin
          etkin_o <= 1'b0;
          pixel_o <= '0;
          if (basla && gorev_i != 2'd3) begin
            bin_ctr  <= '0;
            byte_ctr <= '0;
            acc      <= '0;
            fin      <= 1'b0;
            pix_ctr  <= '0;
            out_ctr  <= '0;
            s1_v     <= 1'b0;
            bolme    <= 1'b0;
            e1_v     <= 1'b0;
            mod_c    <= gorev_i[0];
            durum    <= gorev_i[1] ? LUT : TEMIZLE;
          end
        end
        TEMIZLE: begin
          bin_ctr <= bin_ctr + 1'b1;
          if (bin_ctr == '1) durum <= SAY;
        end
        SAY: begin
          s1_v    <= accept;
          s1_addr <= pixel_i;
          if (accept) pix_ctr <= pix_ctr + 1'b1;
          wr_v    <= s1_v;
          wr_addr <= s1_addr;
          wr_data <= inc_data;
          if (pix_full && !s1_v) durum <= DOK;
        end
        DOK: begin
          if (!etkin_o || !stal_i) begin
            if (fin) begin
              etkin_o <= 1'b0;
              pixel_o <= '0;
              bitti_o <= 1'b1;
              durum   <= BOSTA;
            end else begin
              etkin_o <= 1'b1;
              pixel_o <= dump_word[COUNT_W-1 -: 8];
              sh      <= dump_word << 8;
              if (byte_ctr == '0) acc <= cdf_nx;
              if (byte_ctr == BC_W'(NB - 1)) begin
                byte_ctr <= '0;
                bin_ctr  <= bin_ctr + 1'b1;
                if (bin_ctr == '1) fin <= 1'b1;
              end else begin
                byte_ctr <= byte_ctr + 1'b1;
              end
            end
          end
        end
        LUT: begin
          if (!bolme) begin
            acc   <= cdf_nx;
            rem   <= RW'(cdf_nx) * RW'(BINS - 1);
            quo   <= '0;
            it    <= IT_W'(PIXEL_W - 1);
            bolme <= 1'b1;
          end else begin
            if (q_bit) rem <= rem - dvs;
            quo <= quo_nx;
            if (it == '0) begin
              bolme   <= 1'b0;
              bin_ctr <= bin_ctr + 1'b1;
              if (bin_ctr == '1) durum <= ESITLE;
            end else begin
              it <= it - 1'b1;
            end
          end
        end
        ESITLE: begin
          // Two-stage map pipeline; a stalled sink freezes every stage.
          if (!stal_i) begin
            e1_v <= accept;
            e1_p <= pixel_i;
            if (accept) pix_ctr <= pix_ctr + 1'b1;
            etkin_o <= e1_v;
            pixel_o <= e1_v ? 8'(lut[e1_p]) : 8'd0;
            if (etkin_o) begin
              out_ctr <= out_ctr + 1'b1;
              if (out_ctr == PC_W'(NPIX - 1)) begin
                etkin_o <= 1'b0;
                pixel_o <= '0;
                bitti_o <= 1'b1;
                durum   <= BOSTA;
              end
            end
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end
endmodule

// File: tb/tb_genel_histogram_birimi.sv
module tb_genel_histogram_birimi;
  localparam int PW   = 8;
  localparam int IW   = 8;
  localparam int IH   = 4;
  localparam int CW   = 24;
  localparam int N    = IW * IH;
  localparam int BINS = 256;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       basla = 1'b0;
  logic [1:0] gorev_i = 2'd0;
  logic       etkin_i = 1'b0;
  logic [7:0] pixel_i = 8'd0;
  logic       stal_i = 1'b0;
  logic       etkin_o, stal_o, mesgul_o, bitti_o;
  logic [7:0] pixel_o;

  genel_histogram_birimi #(
    .PIXEL_W(PW), .IMG_W(IW), .IMG_H(IH), .COUNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .basla(basla), .gorev_i(gorev_i),
    .etkin_i(etkin_i), .pixel_i(pixel_i), .stal_i(stal_i),
    .etkin_o(etkin_o), .pixel_o(pixel_o), .stal_o(stal_o),
    .mesgul_o(mesgul_o), .bitti_o(bitti_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int frame[N];
  int hist_ref[BINS];
  int lut_ref[BINS];
  int idx, n_out, n_bitti, tb_mode, exp_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, then observe what the next rising edge moves.
  task automatic step(input logic v, input logic s, input logic b);
    @(negedge clk_i);
    basla   = b;
    stal_i  = s;
    etkin_i = v;
    pixel_i = (idx < N) ? 8'(frame[idx]) : 8'($urandom_range(0, 255));
    #1;
    if (bitti_o) n_bitti++;
    if (etkin_o && !stal_i) begin
      n_out++;
      if (exp_q.size() == 0) chk("extra_out", n_out, exp_total);
      else chk("out_data", pixel_o, exp_q.pop_front());
    end
    if (etkin_i && !stal_o) begin
      if (tb_mode == 2) exp_q.push_back(8'(lut_ref[pixel_i]));
      idx++;
    end
  endtask

  task automatic load_dump(input int mode);
    int c, val;
    c = 0;
    for (int v = 0; v < BINS; v++) hist_ref[v] = 0;
    for (int i = 0; i < N; i++) hist_ref[frame[i]]++;
    for (int v = 0; v < BINS; v++) begin
      c += hist_ref[v];
      val = (mode == 1) ? c : hist_ref[v];
      exp_q.push_back(8'((val >> 16) & 255));
      exp_q.push_back(8'((val >> 8) & 255));
      exp_q.push_back(8'(val & 255));
    end
    exp_total = BINS * 3;
  endtask

  task automatic build_lut();
    int c;
    c = 0;
    for (int v = 0; v < BINS; v++) begin
      c += hist_ref[v];
      lut_ref[v] = (c * 255) / N;
    end
    exp_total = N;
  endtask

  task automatic begin_cmd(input int mode);
    idx = 0;
    n_out = 0;
    n_bitti = 0;
    tb_mode = mode;
    gorev_i = 2'(mode);
    exp_q.delete();
    if (mode < 2) load_dump(mode);
    else build_lut();
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_cmd(input int vkind, input int skind, input int abort_at, input int basla_at);
    int cyc;
    logic v, s;
    cyc = 0;
    n_bitti = 0;
    while (n_bitti == 0 && !(abort_at > 0 && n_out >= abort_at) && cyc < 20000) begin
      v = (vkind == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (skind == 0) s = 1'b0;
      else if (skind == 1) s = cyc[0];
      else s = ($urandom_range(0, 3) == 0);
      step(v, s, cyc == basla_at);
      cyc++;
    end
    chk("cmd_budget", 32'(cyc < 20000), 1);
  endtask

  task automatic end_checks(input string tag);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk({tag, "_accepted"}, idx, N);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_nout"}, n_out, exp_total);
    chk({tag, "_bitti"}, n_bitti, 1);
    chk({tag, "_idle"}, {mesgul_o, etkin_o, pixel_o}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    chk("rst_etkin", etkin_o, 0);
    chk("rst_pixel", pixel_o, 0);
    chk("rst_stal", stal_o, 1);
    chk("rst_mesgul", mesgul_o, 0);
    chk("rst_bitti", bitti_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    exp_q.delete();
  endtask

  int cnt;

  initial begin
    idx = N; n_out = 0; n_bitti = 0; tb_mode = 0; exp_total = 0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("init_etkin", etkin_o, 0);
    chk("init_pixel", pixel_o, 0);
    chk("init_stal", stal_o, 1);
    chk("init_mesgul", mesgul_o, 0);
    chk("init_bitti", bitti_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // mode 3 is ignored
    gorev_i = 2'd3;
    n_bitti = 0;
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    chk("mode3_mesgul", mesgul_o, 0);
    chk("mode3_bitti", n_bitti, 0);

    // constant frame, H then C
    for (int i = 0; i < N; i++) frame[i] = 5;
    begin_cmd(0);
    run_cmd(0, 0, 0, -1);
    end_checks("const_h");
    begin_cmd(1);
    run_cmd(0, 2, 0, -1);
    end_checks("const_c");

    // A,A,A,B,A pattern back to back; basla during SAY is ignored
    for (int i = 0; i < N; i++) frame[i] = ((i % 5) == 3) ? 8'hC3 : 8'h3C;
    begin_cmd(0);
    run_cmd(0, 0, 0, 270);
    end_checks("pattern_h");

    // random frame, random valid and stall
    for (int i = 0; i < N; i++) frame[i] = $urandom_range(0, 255);
    begin_cmd(0);
    run_cmd(1, 2, 0, -1);
    end_checks("rand_h");

    // ramp frame, odd-cycle stall: H, reset, HE
    for (int i = 0; i < N; i++) frame[i] = (i * 7) & 255;
    begin_cmd(0);
    run_cmd(1, 1, 0, -1);
    end_checks("ramp_h");
    do_reset();
    begin_cmd(2);
    run_cmd(1, 1, 0, -1);
    end_checks("ramp_he");

    // C dump aborted by reset after 100 bytes, then HE on the retained histogram
    for (int i = 0; i < N; i++) frame[i] = $urandom_range(0, 15) * 16;
    begin_cmd(1);
    run_cmd(1, 2, 100, -1);
    chk("abort_nout", n_out, 100);
    do_reset();
    for (int i = 0; i < N; i++) frame[i] = $urandom_range(0, 255);
    begin_cmd(2);
    cnt = 0;
    do begin
      step(1'b0, 1'b0, 1'b0);
      cnt++;
    end while (stal_o && cnt < 5000);
    chk("lut_cycles", cnt, BINS * (PW + 1) + 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("lat_1", etkin_o, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("lat_2", etkin_o, 1);
    run_cmd(1, 2, 0, -1);
    end_checks("retained_he");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
